// File: rtl/edge_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module      : edge_pixel_reader
// Description : Scans a complete frame held in BRAM in raster order and
//               writes the {row, col} coordinate of every edge pixel
//               (value > EDGE_THRESHOLD) into a downstream FIFO.
//               Each pixel takes one ISSUE cycle (BRAM read latency) and
//               one CHECK cycle; a full FIFO stalls CHECK on an edge pixel.
// Ports       : clock, reset       - clock, asynchronous active-high reset
//               start              - one-cycle pulse, frame in BRAM ready
//               bram_rd_addr/data  - BRAM read port (1-cycle latency)
//               out_wr_en/out_din  - coordinate FIFO write, {row, col}
//               out_full           - coordinate FIFO full
//               busy               - scan in progress (ISSUE..DONE)
//               done               - one-cycle pulse at end of frame
// Options     : `define ROI_EN restricts edges to rows >= ROI_START_ROW.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pixel_reader #(
    parameter int unsigned WIDTH          = 720,
    parameter int unsigned HEIGHT         = 540,
    parameter int unsigned EDGE_THRESHOLD = 0,
    parameter int unsigned ROI_START_ROW  = 270,
    localparam int unsigned N  = WIDTH * HEIGHT,
    localparam int unsigned AW = $clog2(N),
    localparam int unsigned XW = $clog2(WIDTH),
    localparam int unsigned YW = $clog2(HEIGHT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    bram_rd_addr,
    input  logic [7:0]       bram_rd_data,
    output logic             out_wr_en,
    output logic [YW+XW-1:0] out_din,
    input  logic             out_full,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_WIDTH    = AW'(WIDTH);
    localparam logic [XW-1:0] c_LAST_COL = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_LAST_ROW = YW'(HEIGHT - 1);

    state_t        r_state;
    logic [YW-1:0] r_row;
    logic [XW-1:0] r_col;
    logic          r_busy;
    logic          r_done;

    logic          w_in_roi;
    logic          w_edge;
    logic          w_check;
    logic          w_stall;
    logic          w_last;

`ifdef ROI_EN
    assign w_in_roi = (32'(r_row) >= ROI_START_ROW);
`else
    // Every row is eligible; the ORed term is constant-folded away and only
    // keeps ROI_START_ROW referenced in this build.
    assign w_in_roi = 1'b1 | (32'(r_row) >= ROI_START_ROW);
`endif

    assign w_check = (r_state == S_CHECK);
    assign w_edge  = (32'(bram_rd_data) > EDGE_THRESHOLD) && w_in_roi;
    // An edge pixel that cannot be written holds the counters, so the
    // address and therefore bram_rd_data stay valid until the FIFO drains.
    assign w_stall = w_check && w_edge && out_full;
    assign w_last  = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    assign bram_rd_addr = AW'(r_row) * c_WIDTH + AW'(r_col);
    assign out_wr_en    = w_check && w_edge && !out_full;
    assign out_din      = {r_row, r_col};
    assign busy         = r_busy;
    assign done         = r_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!w_stall) begin
                        if (w_last) begin
                            // Counters are cleared in DONE.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            if (r_col == c_LAST_COL) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_row   <= '0;
                    r_col   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_pixel_reader
// Description : Scoreboard bench for edge_pixel_reader on a 4x3 frame.
//               The driver builds each image and FIFO-full pattern, derives
//               the expected writes (coordinate and cycle) and done cycle
//               from a pixel-level timeline model, and queues them; an
//               independent monitor compares every DUT output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_pixel_reader;

    localparam int W       = 4;
    localparam int H       = 3;
    localparam int NPIX    = W * H;
    localparam int THR     = 48;
    localparam int ROI_ROW = 2;
    localparam int AW      = $clog2(NPIX);
    localparam int DW      = $clog2(H) + $clog2(W);

    typedef struct {
        logic [DW-1:0] din;
        int            cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] bram_rd_addr;
    logic [7:0]    bram_rd_data;
    logic          out_wr_en;
    logic [DW-1:0] out_din;
    logic          out_full;
    logic          busy;
    logic          done;

    logic [7:0] mem [0:(1<<AW)-1];
    bit         fullpat [0:255];
    exp_t       q [$];
    int         exp_done;
    int         tick = 0;
    int         start_tick = 0;
    bit         active = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    edge_pixel_reader #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .EDGE_THRESHOLD(THR),
        .ROI_START_ROW (ROI_ROW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data),
        .out_wr_en   (out_wr_en),
        .out_din     (out_din),
        .out_full    (out_full),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) tick <= tick + 1;
    always @(posedge clock) bram_rd_data <= mem[bram_rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pix_edge(input int v, input int r);
        bit e;
        e = (v > THR);
`ifdef ROI_EN
        if (r < ROI_ROW) e = 1'b0;
`endif
        return e;
    endfunction

    // Pixel p is read at cycle t+1 and checked at t+2; an edge pixel waits
    // while the FIFO is full and is written at the first non-full cycle.
    task automatic plan();
        int t;
        exp_t e;
        q.delete();
        t = 0;
        for (int p = 0; p < NPIX; p++) begin
            t += 2;
            if (pix_edge(int'(mem[p]), p / W)) begin
                while (t < 200 && fullpat[t]) t++;
                e.din = {2'(p / W), 2'(p % W)};
                e.cyc = t;
                q.push_back(e);
            end
        end
        exp_done = t + 1;
    endtask

    task automatic fill_img(input int v);
        for (int i = 0; i < (1 << AW); i++) mem[i] = (i < NPIX) ? 8'(v) : 8'd0;
    endtask

    task automatic clear_full();
        for (int i = 0; i < 256; i++) fullpat[i] = 1'b0;
    endtask

    task automatic rand_frame();
        for (int p = 0; p < NPIX; p++) begin
            case ($urandom_range(0, 4))
                0:       mem[p] = 8'd0;
                1:       mem[p] = 8'(THR);
                2:       mem[p] = 8'(THR + 1);
                default: mem[p] = 8'($urandom_range(0, 255));
            endcase
        end
        for (int i = 0; i < 256; i++)
            fullpat[i] = (i < 150) && ($urandom_range(0, 3) == 0);
    endtask

    // rst_at < 0: no reset; spur < 0: no extra start pulse during the scan.
    task automatic run_frame(input int rst_at, input int spur);
        plan();
        start_tick = tick;
        active     = 1'b1;
        for (int rel = 0; rel <= exp_done + 3; rel++) begin
            if (rel == rst_at) begin
                active   = 1'b0;
                q.delete();
                start    = 1'b0;
                out_full = 1'b0;
                reset    = 1'b1;
                repeat (2) @(negedge clock);
                reset = 1'b0;
                repeat (30) @(negedge clock);
                return;
            end
            start    = (rel == 0) || (rel == spur);
            out_full = fullpat[rel];
            @(negedge clock);
        end
        start    = 1'b0;
        out_full = 1'b0;
        active   = 1'b0;
        chk("missing_writes", q.size(), 0);
    endtask

    int   mon_rel;
    exp_t mon_e;
    always @(negedge clock) begin
        #1;
        mon_rel = tick - start_tick;
        if (reset) begin
            chk("reset_outputs", {out_wr_en, done, busy, out_din, bram_rd_addr}, 0);
        end else if (active) begin
            chk("busy", busy, (mon_rel >= 1) && (mon_rel <= exp_done));
            chk("done", done, mon_rel == exp_done);
            if (out_wr_en) begin
                chk("wr_while_full", out_full, 0);
                if (q.size() == 0) begin
                    chk("unexpected_write", out_wr_en, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("wr_coord", out_din, mon_e.din);
                    chk("wr_cycle", mon_rel, mon_e.cyc);
                end
            end
        end else begin
            chk("idle_done", done, 0);
            chk("idle_wr", out_wr_en, 0);
        end
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        out_full = 1'b0;
        fill_img(0);
        clear_full();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_addr", bram_rd_addr, 0);
        chk("idle_busy", busy, 0);

        // All-zero image: no writes, done at 25.
        fill_img(0);  clear_full();
        run_frame(-1, -1);

        // Edges at pixels 5 and 11.
        fill_img(0);  clear_full();
        mem[5] = 8'd200; mem[11] = 8'd200;
        run_frame(-1, -1);

        // Same image, FIFO full for three cycles at the first edge check.
        fullpat[12] = 1'b1; fullpat[13] = 1'b1; fullpat[14] = 1'b1;
        run_frame(-1, -1);

        // Strict threshold compare.
        fill_img(0);  clear_full();
        mem[0] = 8'(THR); mem[1] = 8'(THR + 1);
        run_frame(-1, -1);

        // Every pixel bright.
        fill_img(255); clear_full();
        run_frame(-1, -1);

        // Reset mid-scan, then a normal scan.
        rand_frame();
        run_frame(10, -1);
        rand_frame();
        run_frame(-1, -1);

        for (int f = 0; f < 20; f++) begin
            rand_frame();
            run_frame(-1, int'($urandom_range(3, 20)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_pixel_reader.md
EDGE_PIXEL_READER -- requirements
Module: edge_pixel_reader

Interface
REQ-001 Parameter WIDTH, 720, image width in pixels.
REQ-002 Parameter HEIGHT, 540, image height in pixels.
REQ-003 Parameter EDGE_THRESHOLD, 0, a pixel is an edge when its value is strictly greater than this.
REQ-004 Parameter ROI_START_ROW, 270, first row inside the region of interest (used only with ROI_EN).
REQ-005 Localparams: N = WIDTH*HEIGHT; AW = $clog2(N); XW = $clog2(WIDTH); YW = $clog2(HEIGHT).
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse from the BRAM writer; the frame in BRAM is complete.
REQ-009 bram_rd_addr  out  AW  BRAM read address, row-major (row*WIDTH+col).
REQ-010 bram_rd_data  in  8  BRAM read data, valid one cycle after the address.
REQ-011 out_wr_en  out  1  write strobe to the downstream coordinate FIFO.
REQ-012 out_din  out  YW+XW  packed {row, col}, with row in the MSBs.
REQ-013 out_full  in  1  downstream FIFO is full.
REQ-014 busy  out  1  high from the first ISSUE cycle through the DONE cycle.
REQ-015 done  out  1  one-cycle pulse when the frame scan completes.

Function
REQ-016 States: IDLE, ISSUE, CHECK, DONE.
REQ-017 Registered counters: col in 0..WIDTH-1, row in 0..HEIGHT-1.
  - bram_rd_addr = row*WIDTH+col, combinational from the counters.
  - bram_rd_addr is driven in every state.
REQ-018 IDLE: when start=1, go to ISSUE on the next cycle; otherwise stay in IDLE.
REQ-019 ISSUE: lasts exactly one cycle (BRAM read latency), then CHECK.
REQ-020 CHECK: bram_rd_data is valid; the pixel is an edge when bram_rd_data > EDGE_THRESHOLD (unsigned compare).
REQ-021 CHECK, edge pixel and out_full=0:
  - assert out_wr_en for that cycle with out_din={row,col};
  - advance the counters.
REQ-022 CHECK, edge pixel and out_full=1:
  - stay in CHECK;
  - hold the counters and the address (data stays valid);
  - out_wr_en=0.
REQ-023 CHECK, non-edge pixel: advance the counters with no write, regardless of out_full.
REQ-024 Advance rule: col+1; at col=WIDTH-1, set col=0 and row+1.
  - After the advance, go to ISSUE.
  - Exception: if the pixel just finished was row=HEIGHT-1, col=WIDTH-1, go to DONE instead.
REQ-025 DONE: assert done for one cycle, clear row and col to 0, then return to IDLE.
REQ-026 out_wr_en is never high outside CHECK, and is never high while out_full=1.
REQ-027 A start pulse outside IDLE is ignored; start has no queueing.
REQ-028 Scan timing with no stalls:
  - each pixel takes exactly 2 cycles;
  - done is high exactly 2N+1 cycles after the cycle in which start was sampled.
  - Each stall cycle adds one cycle.
REQ-029 Coordinates are emitted in strictly increasing raster order, at most once per pixel per frame.

Reset
REQ-030 Reset asynchronously forces: state=IDLE, row=0, col=0.
REQ-031 Output values during reset: out_wr_en=0, done=0, busy=0, out_din=0, bram_rd_addr=0.
REQ-032 Reset mid-scan abandons the frame; no done is produced; the block waits for a new start.

Configuration
REQ-033 Macro ROI_EN.
  - Defined: a pixel with row < ROI_START_ROW is treated as non-edge regardless of bram_rd_data.
  - Not defined: every pixel is eligible and ROI_START_ROW is unused.
  - Cycle timing (REQ-028) is identical in both builds.

Verification
REQ-034 WIDTH=4, HEIGHT=3, all pixels 0, start pulse:
  - no out_wr_en;
  - done at cycle 25 after start;
  - busy high for cycles 1..25.
REQ-035 WIDTH=4, HEIGHT=3, pixels 5 and 11 = 200, others 0, out_full=0:
  - exactly two writes, {1,1} then {2,3};
  - done at cycle 25.
REQ-036 Same image as REQ-035, out_full held high for 3 cycles at the first edge:
  - write {1,1} occurs after out_full falls;
  - done at cycle 28.
REQ-037 EDGE_THRESHOLD=48, pixels 48 and 49 at addresses 0 and 1:
  - only {0,1} is written (strict compare).
REQ-038 ROI_EN defined, ROI_START_ROW=2, all pixels 255:
  - writes only {2,0}..{2,3};
  - done at cycle 25.
  - Without ROI_EN: 12 writes.
REQ-039 Reset asserted at cycle 10 of a scan, then released:
  - outputs go to 0 immediately;
  - no done is produced;
  - a new start then yields a full, correct scan.
